// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the two-port asynchronous SRAM arbiter.
package sram_arb_pkg;

    localparam int ADR_W = 19;
    localparam int DAT_W = 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-requester round-robin arbiter: combinational one-hot grant, registered last-grant pointer.
module sram_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    logic last_p1;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_p1 ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Pointer only moves when the sequencer actually consumes the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_p1 <= 1'b1;
        end else if (take && (req != 2'b00)) begin
            last_p1 <= grant[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and access sequencer for an 8-bit asynchronous SRAM.
//
//   state     | meaning
//   ST_IDLE   | bus released, waiting for a request to grant
//   ST_SETUP  | ce_n low, address (and write data) presented, strobes high
//   ST_ACCESS | oe_n or we_n low for WAIT_CYCLES cycles
//   ST_HOLD   | strobes high, address/data held, ack pulse to granted port
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [ADR_W-1:0] p0_adr,
    input  logic [DAT_W-1:0] p0_wdat,
    output logic             p0_ack,
    output logic [DAT_W-1:0] p0_rdat,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [ADR_W-1:0] p1_adr,
    input  logic [DAT_W-1:0] p1_wdat,
    output logic             p1_ack,
    output logic [DAT_W-1:0] p1_rdat,
    output logic [ADR_W-1:0] sram_adr,
    inout  wire  [DAT_W-1:0] sram_dat,
    output logic             sram_ce_n,
    output logic             sram_oe_n,
    output logic             sram_we_n,
    output logic             sram_lb,
    output logic             sram_ub,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       gnt_q;
    logic             we_q;
    logic [DAT_W-1:0] wdat_q;
    logic             dat_oe;
    logic [1:0]       grant;
    logic             sel_p1;

    sram_rr_arb u_rr (
        .clk   (clk),
        .reset (reset),
        .req   ({p1_req, p0_req}),
        .take  (state == ST_IDLE),
        .grant (grant)
    );

    assign sel_p1 = grant[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            gnt_q     <= 2'b00;
            we_q      <= 1'b0;
            wdat_q    <= '0;
            dat_oe    <= 1'b0;
            sram_adr  <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rdat   <= '0;
            p1_rdat   <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        gnt_q     <= grant;
                        we_q      <= sel_p1 ? p1_we   : p0_we;
                        sram_adr  <= sel_p1 ? p1_adr  : p0_adr;
                        wdat_q    <= sel_p1 ? p1_wdat : p0_wdat;
                        dat_oe    <= sel_p1 ? p1_we   : p0_we;
                        sram_ce_n <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt       <= CNT_W'(WAIT_CYCLES - 1);
                    sram_oe_n <= we_q;
                    sram_we_n <= ~we_q;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        p0_ack    <= gnt_q[0];
                        p1_ack    <= gnt_q[1];
                        // Sampled while oe_n is still low on this edge.
                        if (!we_q && gnt_q[0]) p0_rdat <= sram_dat;
                        if (!we_q && gnt_q[1]) p1_rdat <= sram_dat;
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    sram_ce_n <= 1'b1;
                    dat_oe    <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sram_dat = dat_oe ? wdat_q : 'z;
    assign sram_lb  = sram_ce_n;
    assign sram_ub  = 1'b1;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-wait instance plus a WAIT_CYCLES=1 instance.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // instance A, default wait
    logic        a_p0_req = 0, a_p1_req = 0, a_p0_we = 0, a_p1_we = 0;
    logic [18:0] a_p0_adr = 0, a_p1_adr = 0;
    logic [7:0]  a_p0_wdat = 0, a_p1_wdat = 0;
    logic        a_p0_ack, a_p1_ack, a_ce_n, a_oe_n, a_we_n, a_lb, a_ub, a_busy;
    logic [7:0]  a_p0_rdat, a_p1_rdat;
    logic [18:0] a_adr;
    wire  [7:0]  a_dat;
    logic [7:0]  a_model = 8'h00;

    assign a_dat = a_oe_n ? 8'hzz : a_model;
    pulldown (a_dat);

    sram_arbiter u_a (
        .clk(clk), .reset(reset),
        .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_adr(a_p0_adr), .p0_wdat(a_p0_wdat),
        .p0_ack(a_p0_ack), .p0_rdat(a_p0_rdat),
        .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_adr(a_p1_adr), .p1_wdat(a_p1_wdat),
        .p1_ack(a_p1_ack), .p1_rdat(a_p1_rdat),
        .sram_adr(a_adr), .sram_dat(a_dat), .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n),
        .sram_we_n(a_we_n), .sram_lb(a_lb), .sram_ub(a_ub), .busy(a_busy)
    );

    // instance B, single-cycle strobe, backed by a 16-entry memory model
    logic        b_p0_req = 0, b_p1_req = 0, b_p0_we = 0, b_p1_we = 0;
    logic [18:0] b_p0_adr = 0, b_p1_adr = 0;
    logic [7:0]  b_p0_wdat = 0, b_p1_wdat = 0;
    logic        b_p0_ack, b_p1_ack, b_ce_n, b_oe_n, b_we_n, b_lb, b_ub, b_busy;
    logic [7:0]  b_p0_rdat, b_p1_rdat;
    logic [18:0] b_adr;
    wire  [7:0]  b_dat;
    logic [7:0]  b_mem [16];
    logic [7:0]  shadow [16];

    assign b_dat = b_oe_n ? 8'hzz : b_mem[b_adr[3:0]];
    pulldown (b_dat);

    always @(posedge clk) begin
        if (!b_ce_n && !b_we_n) b_mem[b_adr[3:0]] <= b_dat;
    end

    sram_arbiter #(.WAIT_CYCLES(1)) u_b (
        .clk(clk), .reset(reset),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_adr(b_p0_adr), .p0_wdat(b_p0_wdat),
        .p0_ack(b_p0_ack), .p0_rdat(b_p0_rdat),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_adr(b_p1_adr), .p1_wdat(b_p1_wdat),
        .p1_ack(b_p1_ack), .p1_rdat(b_p1_rdat),
        .sram_adr(b_adr), .sram_dat(b_dat), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n),
        .sram_we_n(b_we_n), .sram_lb(b_lb), .sram_ub(b_ub), .busy(b_busy)
    );

    int   contention = 0;
    logic b_rd_active = 1'b0;

    always @(negedge clk) begin
        if (!b_oe_n && !b_we_n) contention++;
        if (b_rd_active && b_oe_n && (b_dat !== 8'h00)) contention++;
        if (b_ce_n && (b_dat !== 8'h00)) contention++;
    end

    initial begin
        logic [1:0]  exp_ack;
        logic        port_sel, wr;
        logic [3:0]  idx;
        logic [14:0] hi;
        logic [7:0]  wd;
        logic        got;
        int          lat;

        for (int i = 0; i < 16; i++) begin
            b_mem[i]  = 8'h00;
            shadow[i] = 8'h00;
        end

        // reset state
        tick();
        tick();
        chk("rst_ce_n", 32'(a_ce_n), 32'd1);
        chk("rst_oe_n", 32'(a_oe_n), 32'd1);
        chk("rst_we_n", 32'(a_we_n), 32'd1);
        chk("rst_ub_lb", 32'({a_ub, a_lb}), 32'h3);
        chk("rst_adr", 32'(a_adr), 32'h0);
        chk("rst_ack", 32'({a_p1_ack, a_p0_ack}), 32'h0);
        chk("rst_rdat", 32'({a_p1_rdat, a_p0_rdat}), 32'h0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_bus", 32'(a_dat), 32'h0);
        reset = 1'b0;
        tick();

        // p0 write 0xFF to 0x000AA; req dropped once granted
        a_p0_req = 1; a_p0_we = 1; a_p0_adr = 19'h000AA; a_p0_wdat = 8'hFF;
        tick();
        a_p0_req = 0;
        chk("wr_setup_busy", 32'(a_busy), 32'd1);
        chk("wr_setup_ce_lb", 32'({a_ce_n, a_lb}), 32'h0);
        chk("wr_setup_strobes", 32'({a_oe_n, a_we_n}), 32'h3);
        chk("wr_setup_adr", 32'(a_adr), 32'h000AA);
        chk("wr_setup_bus", 32'(a_dat), 32'hFF);
        tick();
        chk("wr_acc1_strobes", 32'({a_oe_n, a_we_n}), 32'h2);
        chk("wr_acc1_bus", 32'(a_dat), 32'hFF);
        chk("wr_acc1_ack", 32'({a_p1_ack, a_p0_ack}), 32'h0);
        tick();
        chk("wr_acc2_strobes", 32'({a_oe_n, a_we_n}), 32'h2);
        tick();
        chk("wr_hold_strobes", 32'({a_oe_n, a_we_n}), 32'h3);
        chk("wr_hold_ce", 32'(a_ce_n), 32'd0);
        chk("wr_hold_bus", 32'(a_dat), 32'hFF);
        chk("wr_hold_adr", 32'(a_adr), 32'h000AA);
        chk("wr_hold_ack", 32'({a_p1_ack, a_p0_ack}), 32'h1);
        tick();
        chk("wr_idle_ack", 32'({a_p1_ack, a_p0_ack}), 32'h0);
        chk("wr_idle_busy", 32'(a_busy), 32'd0);
        chk("wr_idle_ce", 32'(a_ce_n), 32'd1);
        chk("wr_idle_bus", 32'(a_dat), 32'h0);

        // p1 read of 0x000AA, memory returns 0xF0
        a_model = 8'hF0;
        a_p1_req = 1; a_p1_we = 0; a_p1_adr = 19'h000AA;
        tick();
        chk("rd_setup_bus", 32'(a_dat), 32'h0);
        chk("rd_setup_strobes", 32'({a_oe_n, a_we_n}), 32'h3);
        tick();
        chk("rd_acc1_strobes", 32'({a_oe_n, a_we_n}), 32'h1);
        chk("rd_acc1_bus", 32'(a_dat), 32'hF0);
        tick();
        chk("rd_acc2_strobes", 32'({a_oe_n, a_we_n}), 32'h1);
        tick();
        chk("rd_hold_ack", 32'({a_p1_ack, a_p0_ack}), 32'h2);
        chk("rd_hold_p1_rdat", 32'(a_p1_rdat), 32'hF0);
        chk("rd_hold_p0_rdat", 32'(a_p0_rdat), 32'h00);
        chk("rd_hold_oe", 32'(a_oe_n), 32'd1);
        a_p1_req = 0;
        tick();
        chk("rd_idle_busy", 32'(a_busy), 32'd0);

        // both ports requesting continuously from reset: p0 wins first tie, then alternate
        reset = 1;
        tick();
        reset = 0;
        a_model = 8'h5A;
        a_p0_req = 1; a_p0_we = 0; a_p0_adr = 19'h00001;
        a_p1_req = 1; a_p1_we = 0; a_p1_adr = 19'h00002;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 4 || c == 14)      exp_ack = 2'b01;
            else if (c == 9 || c == 19) exp_ack = 2'b10;
            else                        exp_ack = 2'b00;
            chk("rr_ack", 32'({a_p1_ack, a_p0_ack}), 32'(exp_ack));
            if (c == 1 || c == 11) chk("rr_adr_p0", 32'(a_adr), 32'h1);
            if (c == 6 || c == 16) chk("rr_adr_p1", 32'(a_adr), 32'h2);
        end
        a_p0_req = 0; a_p1_req = 0;
        tick();

        // reset in the first ACCESS cycle of a write aborts without ack
        a_p0_req = 1; a_p0_we = 1; a_p0_adr = 19'h12345; a_p0_wdat = 8'h5A;
        tick();
        a_p0_req = 0;
        tick();
        chk("abort_acc_we", 32'(a_we_n), 32'd0);
        reset = 1;
        #1;
        chk("abort_we_n", 32'(a_we_n), 32'd1);
        chk("abort_ce_n", 32'(a_ce_n), 32'd1);
        chk("abort_bus", 32'(a_dat), 32'h0);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_ack", 32'({a_p1_ack, a_p0_ack}), 32'h0);
        tick();
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_noack", 32'({a_p1_ack, a_p0_ack}), 32'h0);
        end
        a_model = 8'h3C;
        a_p1_req = 1; a_p1_we = 0; a_p1_adr = 19'h00777;
        tick(); tick(); tick();
        chk("post_abort_early", 32'({a_p1_ack, a_p0_ack}), 32'h0);
        tick();
        chk("post_abort_ack", 32'({a_p1_ack, a_p0_ack}), 32'h2);
        chk("post_abort_rdat", 32'(a_p1_rdat), 32'h3C);
        a_p1_req = 0;
        tick();

        // WAIT_CYCLES=1: single-cycle strobe, ack three cycles after request
        b_p0_req = 1; b_p0_we = 1; b_p0_adr = 19'h00005; b_p0_wdat = 8'h77;
        tick();
        chk("w1_setup_we", 32'(b_we_n), 32'd1);
        tick();
        chk("w1_acc_we", 32'(b_we_n), 32'd0);
        tick();
        chk("w1_hold_we", 32'(b_we_n), 32'd1);
        chk("w1_hold_ack", 32'({b_p1_ack, b_p0_ack}), 32'h1);
        b_p0_req = 0;
        shadow[5] = 8'h77;
        tick();

        for (int k = 0; k < 100; k++) begin
            port_sel = 1'($urandom_range(0, 1));
            wr       = 1'($urandom_range(0, 1));
            idx      = 4'($urandom_range(0, 15));
            hi       = 15'($urandom_range(0, 32767));
            wd       = 8'($urandom_range(0, 255));
            b_rd_active = !wr;
            if (port_sel) begin
                b_p1_req = 1; b_p1_we = wr; b_p1_adr = {hi, idx}; b_p1_wdat = wd;
            end else begin
                b_p0_req = 1; b_p0_we = wr; b_p0_adr = {hi, idx}; b_p0_wdat = wd;
            end
            lat = 0;
            got = 1'b0;
            while (!got && lat < 10) begin
                tick();
                lat++;
                got = port_sel ? b_p1_ack : b_p0_ack;
            end
            chk("rnd_latency", 32'(lat), 32'd3);
            b_p0_req = 0;
            b_p1_req = 0;
            if (!wr) chk("rnd_rdat", 32'(port_sel ? b_p1_rdat : b_p0_rdat), 32'(shadow[idx]));
            else shadow[idx] = wd;
            b_rd_active = 1'b0;
            tick();
        end
        chk("contention", 32'(contention), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of cycles the OE/WE strobe is held low (legal 1..15).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports p0_req/p1_req, input, 1, access request, held until ack.
REQ-005 SHALL have ports p0_we/p1_we, input, 1, 1 = write, 0 = read.
REQ-006 SHALL have ports p0_adr/p1_adr, input, 19, word address.
REQ-007 SHALL have ports p0_wdat/p1_wdat, input, 8, write data.
REQ-008 SHALL have ports p0_ack/p1_ack, output, 1, single-cycle completion pulse.
REQ-009 SHALL have ports p0_rdat/p1_rdat, output, 8, read data of that port's last completed read.
REQ-010 SHALL have port sram_adr, output, 19, SRAM address.
REQ-011 SHALL have port sram_dat, inout, 8, SRAM data bus.
REQ-012 SHALL have ports sram_ce_n/sram_oe_n/sram_we_n, output, 1 each, active-low chip enable, output enable, write enable.
REQ-013 SHALL have ports sram_lb/sram_ub, output, 1 each, active-low byte enables.
REQ-014 SHALL have port busy, output, 1, high in every non-IDLE state.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> ACCESS -> HOLD -> IDLE; HOLD always returns to IDLE (one mandatory turnaround cycle).
REQ-016 IDLE: if any req is high at the clock edge, SHALL grant one port, latch its we/adr/wdat, and enter SETUP; otherwise stay.
REQ-017 SHALL arbitrate round-robin: single requester wins; on simultaneous requests the port not granted last wins; the last-grant pointer updates only on grant.
REQ-018 SETUP: sram_ce_n=0, sram_lb=0, sram_adr=latched address, oe_n=we_n=1; on write, sram_dat driven with latched wdat.
REQ-019 ACCESS: exactly WAIT_CYCLES cycles, 4-bit down-counter; read asserts oe_n=0, write asserts we_n=0 and keeps driving data.
REQ-020 Read data SHALL be captured from sram_dat at the clock edge ending the last ACCESS cycle, into the granted port's rdat register.
REQ-021 HOLD: oe_n=we_n=1, ce_n=0, address and write data held; the granted port's ack=1 for this cycle only.
REQ-022 Latency: ack SHALL be high WAIT_CYCLES+2 cycles after the IDLE cycle sampling req (4 cycles with default); throughput one access per WAIT_CYCLES+3 cycles.
REQ-023 sram_dat SHALL be high-Z in IDLE and in all read states; never driven while sram_oe_n=0.
REQ-024 sram_ub SHALL be constant 1; sram_lb SHALL equal sram_ce_n.
REQ-025 A req dropped before grant SHALL be ignored; once granted, the access SHALL complete regardless of req.
REQ-026 The non-granted port's ack and rdat SHALL remain unchanged during another port's access.
REQ-027 sram_oe_n and sram_we_n SHALL never be low simultaneously.

Reset
REQ-028 While reset=1 (asynchronously): state=IDLE, ce_n/oe_n/we_n/ub/lb=1, sram_adr=0, sram_dat high-Z, acks=0, rdats=0x00, busy=0, last-grant=port 1 (port 0 wins the first tie).
REQ-029 Reset during any non-IDLE state SHALL abort the access immediately with no ack issued; the first request after release SHALL start from IDLE.

Structure
REQ-030 Package sram_arb_pkg SHALL hold the state enumeration, ADR_W=19, DAT_W=8 and the wait-counter width constant.
REQ-031 Round-robin grant logic SHALL be sub-module sram_rr_arb (2 requests in, one-hot grant out, pointer register inside); sequencing and tristate stay in sram_arbiter.

Verification
REQ-032 p0 write adr=0x000AA wdat=0xFF -> SETUP, we_n low 2 cycles, p0_ack in 4th cycle after request; sram_dat=0xFF from SETUP through HOLD; sram_dat high-Z afterwards.
REQ-033 p1 read adr=0x000AA, SRAM model drives 0xF0 while oe_n=0 -> p1_ack after 4 cycles, p1_rdat=0xF0, p0_rdat unchanged at 0x00.
REQ-034 p0 and p1 requesting continuously from reset -> grants alternate p0,p1,p0,p1; one ack every 5 cycles; no ack overlap.
REQ-035 Reset asserted in the 1st ACCESS cycle of a write -> we_n/ce_n=1 and bus high-Z immediately, no ack; a subsequent read completes normally.
REQ-036 WAIT_CYCLES=1 -> strobe low exactly 1 cycle, ack 3 cycles after request; a bus monitor flags zero contention over 100 random accesses.
